// File: rtl/qif_neuron_array.sv
// Multi-channel quadratic integrate-and-fire neuron array with absolute refractory
// period and a saturating population spike counter.
module qif_neuron_array #(
    parameter int WIDTH        = 8,
    parameter int N_CH         = 4,
    parameter int V_TH         = 200,
    parameter int V_RESET      = 0,
    parameter int SQ_SHIFT     = 6,
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRAC_STEPS = 3,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    mode,
    input  logic [N_CH*WIDTH-1:0]   I_syn,
    input  logic                    clr_cnt,
    output logic [N_CH-1:0]         spike,
    output logic [N_CH*WIDTH-1:0]   V_mem,
    output logic [N_CH-1:0]         refrac,
    output logic [CNT_W-1:0]        spike_cnt
);

    localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam int SW   = 2 * WIDTH + 2;
    localparam int PC_W = $clog2(N_CH + 1);
    localparam int CW   = CNT_W + PC_W;

    localparam logic [WIDTH-1:0] V_RST   = WIDTH'(V_RESET);
    localparam logic [WIDTH-1:0] TH      = WIDTH'(V_TH);
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REFRAC_STEPS);
    localparam logic [SW-1:0]    V_MAX   = {{(WIDTH + 2){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [CW-1:0]    C_MAX   = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    logic [N_CH*WIDTH-1:0] v_q, v_d;
    logic [N_CH*RC_W-1:0]  rc_q, rc_d;
    logic [N_CH-1:0]       spike_q, spike_d;
    logic [N_CH-1:0]       refrac_q, refrac_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [WIDTH-1:0]   v;
            logic [WIDTH-1:0]   i_in;
            logic [2*WIDTH-1:0] vv;
            logic [2*WIDTH-1:0] sq;
            logic [WIDTH-1:0]   leak;
            logic [SW-1:0]      sum;
            logic [WIDTH-1:0]   nxt;
            logic [RC_W-1:0]    rc;
            logic [RC_W-1:0]    rc_nxt;
            logic               busy;
            logic               fire;

            assign v    = v_q[gi*WIDTH +: WIDTH];
            assign i_in = I_syn[gi*WIDTH +: WIDTH];
            assign rc   = rc_q[gi*RC_W +: RC_W];
            assign busy = (rc != '0);

            assign vv   = {{WIDTH{1'b0}}, v} * {{WIDTH{1'b0}}, v};
            assign sq   = mode ? '0 : (vv >> SQ_SHIFT);
            assign leak = v >> LEAK_SHIFT;
            // leak never exceeds v, so the subtraction cannot wrap
            assign sum  = {{(WIDTH + 2){1'b0}}, v} + {2'b00, sq}
                        + {{(WIDTH + 2){1'b0}}, i_in} - {{(WIDTH + 2){1'b0}}, leak};
            assign nxt  = (sum > V_MAX) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            assign fire = (nxt >= TH);

            assign rc_nxt = !step ? rc
                          : busy  ? rc - RC_W'(1)
                          : fire  ? RC_LOAD
                          : rc;

            assign v_d[gi*WIDTH +: WIDTH] = !step ? v
                                          : (busy || fire) ? V_RST
                                          : nxt;
            assign rc_d[gi*RC_W +: RC_W]  = rc_nxt;
            assign spike_d[gi]            = step && !busy && fire;
            assign refrac_d[gi]           = (rc_nxt != '0);
        end
    endgenerate

    logic [PC_W-1:0] pop;
    logic [CW-1:0]   cnt_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + PC_W'(spike_d[i]);
        end
        cnt_sum = CW'(cnt_q) + CW'(pop);
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (cnt_sum > C_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= {N_CH{V_RST}};
            rc_q     <= '0;
            spike_q  <= '0;
            refrac_q <= '0;
            cnt_q    <= '0;
        end else begin
            v_q      <= v_d;
            rc_q     <= rc_d;
            spike_q  <= spike_d;
            refrac_q <= refrac_d;
            cnt_q    <= cnt_d;
        end
    end

    assign V_mem     = v_q;
    assign spike     = spike_q;
    assign refrac    = refrac_q;
    assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Directed checks of qif_neuron_array; a second instance with a 3-bit counter
// exercises spike_cnt saturation on the same stimulus.
module tb_qif_neuron_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step;
    logic        mode;
    logic [31:0] i_syn;
    logic        clr_cnt;
    logic [3:0]  spike, spike2;
    logic [31:0] v_mem, v_mem2;
    logic [3:0]  refrac, refrac2;
    logic [15:0] spike_cnt;
    logic [2:0]  spike_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qif_neuron_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .mode      (mode),
        .I_syn     (i_syn),
        .clr_cnt   (clr_cnt),
        .spike     (spike),
        .V_mem     (v_mem),
        .refrac    (refrac),
        .spike_cnt (spike_cnt)
    );

    qif_neuron_array #(.CNT_W(3)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .mode      (mode),
        .I_syn     (i_syn),
        .clr_cnt   (clr_cnt),
        .spike     (spike2),
        .V_mem     (v_mem2),
        .refrac    (refrac2),
        .spike_cnt (spike_cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s = %0d", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step    = 1'b0;
        clr_cnt = 1'b0;
        mode    = 1'b0;
        i_syn   = '0;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    function automatic logic [7:0] vch(input int ch);
        return v_mem[ch*8 +: 8];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        step    = 1'b0;
        mode    = 1'b0;
        i_syn   = '0;
        clr_cnt = 1'b0;
        #12;
        check_val("rst_vmem",   v_mem,     32'd0);
        check_val("rst_spike",  spike,     32'd0);
        check_val("rst_refrac", refrac,    32'd0);
        check_val("rst_cnt",    spike_cnt, 32'd0);
        tick();
        rst_n = 1'b1;

        // quadratic integration on ch0
        i_syn = {8'd0, 8'd0, 8'd0, 8'd10};
        step  = 1'b1;
        tick();
        check_val("qif_v0_s1", vch(0), 32'd10);
        check_val("qif_others_s1", v_mem[31:8], 32'd0);
        tick();
        check_val("qif_v0_s2", vch(0), 32'd20);
        tick();
        check_val("qif_v0_s3", vch(0), 32'd34);
        check_val("qif_spike", spike, 32'd0);

        // saturation and refractory on ch1
        apply_reset();
        i_syn = {8'd0, 8'd0, 8'd255, 8'd0};
        step  = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            tick();
            check_val($sformatf("ref_spike_s%0d", s), spike, (s % 4 == 1) ? 32'd2 : 32'd0);
            check_val($sformatf("ref_refrac_s%0d", s), refrac, (s % 4 != 0) ? 32'd2 : 32'd0);
            check_val($sformatf("ref_v1_s%0d", s), vch(1), 32'd0);
        end
        check_val("ref_cnt", spike_cnt, 32'd3);

        // linear mode on ch2
        apply_reset();
        mode  = 1'b1;
        i_syn = {8'd0, 8'd10, 8'd0, 8'd0};
        step  = 1'b1;
        tick();
        check_val("lif_v2_s1", vch(2), 32'd10);
        tick();
        check_val("lif_v2_s2", vch(2), 32'd19);
        tick();
        check_val("lif_v2_s3", vch(2), 32'd27);
        step = 1'b0;
        mode = 1'b0;

        // step gating, then all-channel spikes and counter saturation
        apply_reset();
        i_syn = {4{8'd255}};
        repeat (20) tick();
        check_val("gate_vmem",  v_mem,     32'd0);
        check_val("gate_spike", spike,     32'd0);
        check_val("gate_cnt",   spike_cnt, 32'd0);
        step = 1'b1;
        tick();
        check_val("all_spike_s1", spike,      32'd15);
        check_val("all_cnt_s1",   spike_cnt,  32'd4);
        check_val("small_cnt_s1", spike_cnt2, 32'd4);
        tick();
        check_val("all_spike_s2", spike,  32'd0);
        check_val("all_refrac_s2", refrac, 32'd15);
        repeat (3) tick();
        check_val("all_spike_s5", spike,      32'd15);
        check_val("all_cnt_s5",   spike_cnt,  32'd8);
        check_val("small_cnt_s5", spike_cnt2, 32'd7);
        repeat (4) tick();
        check_val("all_cnt_s9",   spike_cnt,  32'd12);
        check_val("small_cnt_s9", spike_cnt2, 32'd7);

        // clear has priority over same-edge spikes; clear works without step
        apply_reset();
        i_syn   = {4{8'd255}};
        step    = 1'b1;
        clr_cnt = 1'b1;
        tick();
        check_val("clr_spike", spike,     32'd15);
        check_val("clr_cnt",   spike_cnt, 32'd0);
        clr_cnt = 1'b0;
        repeat (4) tick();
        check_val("clr_after_cnt", spike_cnt, 32'd4);
        step    = 1'b0;
        clr_cnt = 1'b1;
        tick();
        check_val("clr_nostep_cnt", spike_cnt, 32'd0);
        clr_cnt = 1'b0;

        // asynchronous reset in the middle of a refractory period
        apply_reset();
        i_syn = {8'd0, 8'd0, 8'd255, 8'd0};
        step  = 1'b1;
        tick();
        check_val("ar_refrac_pre", refrac, 32'd2);
        check_val("ar_spike_pre",  spike,  32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_vmem",   v_mem,     32'd0);
        check_val("ar_spike",  spike,     32'd0);
        check_val("ar_refrac", refrac,    32'd0);
        check_val("ar_cnt",    spike_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("ar_first_spike", spike,     32'd2);
        check_val("ar_first_cnt",   spike_cnt, 32'd1);
        step = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
